multi_drive_resolver: RTL and testbench

Parametrised, clocked successor to our multi-driven-net fuzz blocks. N 4-state drivers share one W-bit net. The block resolves them per bit under a selectable net type (tri/wor/wand). It captures the resolved value through a request/acknowledge handshake, keeps contention and X/Z statistics, and replaces the combinational self-inverting loop with a registered toggle.

---
 rtl/multi_drive_resolver_pkg.sv | 51 +++++
 rtl/multi_drive_resolver_if.sv | 43 ++++
 rtl/multi_drive_resolver_bit_resolve.sv | 62 ++++++
 rtl/multi_drive_resolver.sv | 132 +++++++++++++
 tb/tb_multi_drive_resolver.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_drive_resolver_pkg.sv
// -----------------------------------------------------------------------------
// mdr_pkg
// Shared types for the multi-driven-net resolver.
//
// Every net/driver bit carries its 4-state level as an explicit 2-bit code
// (lv_e). The resolver then behaves the same on 2-state and 4-state
// simulators and in synthesis, where real x/z values do not exist.
//
// Contents:
//   lv_e        : 4-state level code (0, 1, x, z)
//   mdr_mode_e  : net type (tri / wor / wand)
//   mdr_state_e : capture FSM states
//   lv_is_xz    : true for an x or z level
//   mode_dominant / mode_recessive : per-mode priority constants
// -----------------------------------------------------------------------------
package mdr_pkg;

  typedef enum logic [1:0] {
    LV_0 = 2'b00,
    LV_1 = 2'b01,
    LV_X = 2'b10,
    LV_Z = 2'b11
  } lv_e;

  typedef enum logic [1:0] {
    MDR_TRI  = 2'd0,
    MDR_WOR  = 2'd1,
    MDR_WAND = 2'd2
  } mdr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } mdr_state_e;

  function automatic logic lv_is_xz(input lv_e v);
    return (v == LV_X) || (v == LV_Z);
  endfunction

  // Value that wins outright on a wired net (1 for wor, 0 for wand).
  function automatic lv_e mode_dominant(input mdr_mode_e m);
    return (m == MDR_WAND) ? LV_0 : LV_1;
  endfunction

  // Value that only shows when nothing stronger is present.
  function automatic lv_e mode_recessive(input mdr_mode_e m);
    return (m == MDR_WAND) ? LV_1 : LV_0;
  endfunction

endpackage

// File: rtl/multi_drive_resolver_if.sv
// -----------------------------------------------------------------------------
// multi_drive_resolver_if
// Bus bundle between the driver side (master) and the resolver (slave).
//
//   drv_en       : per-driver enable; disabled drivers contribute z
//   drv_val      : per-driver 4-state values (lv_e codes)
//   sample_req   : capture request, level, held until ack seen
//   stat_clr     : single-cycle clear of conflict_cnt / xz_seen
//   sample_ack   : capture done, res_q valid
//   res_q        : captured resolved net value
//   conflict_q   : last capture had contention
//   xz_seen      : sticky, some capture contained x or z
//   conflict_cnt : saturating count of conflicting captures
// -----------------------------------------------------------------------------
interface multi_drive_resolver_if
  import mdr_pkg::*;
#(
  parameter int unsigned NUM_DRV = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 16
) ();

  logic [NUM_DRV-1:0]            drv_en;
  lv_e  [NUM_DRV-1:0][WIDTH-1:0] drv_val;
  logic                          sample_req;
  logic                          stat_clr;
  logic                          sample_ack;
  lv_e  [WIDTH-1:0]              res_q;
  logic                          conflict_q;
  logic                          xz_seen;
  logic [CNT_W-1:0]              conflict_cnt;

  modport master (
    output drv_en, drv_val, sample_req, stat_clr,
    input  sample_ack, res_q, conflict_q, xz_seen, conflict_cnt
  );

  modport slave (
    input  drv_en, drv_val, sample_req, stat_clr,
    output sample_ack, res_q, conflict_q, xz_seen, conflict_cnt
  );

endinterface

// File: rtl/multi_drive_resolver_bit_resolve.sv
// -----------------------------------------------------------------------------
// mdr_bit_resolve
// Resolves one bit position of the shared net from all drivers.
//
//   en_i       : per-driver enable
//   bit_i      : this bit from every driver
//   res_o      : resolved level under the selected net type
//   conflict_o : enabled drivers present both 0 and 1 on this bit
// -----------------------------------------------------------------------------
module mdr_bit_resolve
  import mdr_pkg::*;
#(
  parameter int unsigned NUM_DRV = 4,
  parameter int unsigned MODE    = 0
) (
  input  logic [NUM_DRV-1:0] en_i,
  input  lv_e  [NUM_DRV-1:0] bit_i,
  output lv_e                res_o,
  output logic               conflict_o
);

  localparam mdr_mode_e NET_MODE = mdr_mode_e'(MODE[1:0]);

  logic seen0, seen1, seenx;

  // Summarise the contributors; z and disabled drivers add nothing.
  always_comb begin
    seen0 = 1'b0;
    seen1 = 1'b0;
    seenx = 1'b0;
    for (int unsigned d = 0; d < NUM_DRV; d++) begin
      if (en_i[d]) begin
        case (bit_i[d])
          LV_0:    seen0 = 1'b1;
          LV_1:    seen1 = 1'b1;
          LV_X:    seenx = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign conflict_o = seen0 & seen1;

  always_comb begin
    res_o = LV_Z;
    if (NET_MODE == MDR_TRI) begin
      if (seenx || (seen0 && seen1)) res_o = LV_X;
      else if (seen1)                res_o = LV_1;
      else if (seen0)                res_o = LV_0;
    end else begin
      // wor and wand differ only in which level dominates.
      logic dom_seen, rec_seen;
      dom_seen = (NET_MODE == MDR_WAND) ? seen0 : seen1;
      rec_seen = (NET_MODE == MDR_WAND) ? seen1 : seen0;
      if (dom_seen)      res_o = mode_dominant(NET_MODE);
      else if (seenx)    res_o = LV_X;
      else if (rec_seen) res_o = mode_recessive(NET_MODE);
    end
  end

endmodule

// File: rtl/multi_drive_resolver.sv
// -----------------------------------------------------------------------------
// multi_drive_resolver
// N 4-state drivers on one W-bit net, resolved per bit (tri/wor/wand),
// captured through a req/ack handshake with contention and x/z statistics,
// plus a registered toggle replacing the old self-inverting loop.
//
//   clk     : clock
//   rst     : synchronous active-high reset
//   bus     : slave side of multi_drive_resolver_if
//   loop_en : enable the registered inverter feedback
//   loop_q  : feedback register
//
// Handshake: req seen at edge t -> CAPTURE; edge t+1 latches the net into
// res_q; sample_ack is registered from the HOLD state so it rises after
// edge t+2 and falls one cycle after the FSM leaves HOLD.
// -----------------------------------------------------------------------------
module multi_drive_resolver
  import mdr_pkg::*;
#(
  parameter int unsigned NUM_DRV = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODE    = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  multi_drive_resolver_if.slave  bus,
  input  logic                   loop_en,
  output logic                   loop_q
);

  // Transposed view: one column of driver bits per net bit.
  lv_e  [NUM_DRV-1:0] col_w [WIDTH];
  lv_e  [WIDTH-1:0]   res_w;
  logic [WIDTH-1:0]   bit_conf_w;
  logic               conflict_w;
  logic               any_xz_w;

  always_comb begin
    for (int unsigned b = 0; b < WIDTH; b++) begin
      for (int unsigned d = 0; d < NUM_DRV; d++) begin
        col_w[b][d] = bus.drv_val[d][b];
      end
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    mdr_bit_resolve #(
      .NUM_DRV (NUM_DRV),
      .MODE    (MODE)
    ) u_resolve (
      .en_i       (bus.drv_en),
      .bit_i      (col_w[b]),
      .res_o      (res_w[b]),
      .conflict_o (bit_conf_w[b])
    );
  end

  assign conflict_w = |bit_conf_w;

  always_comb begin
    any_xz_w = 1'b0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (lv_is_xz(res_w[b])) any_xz_w = 1'b1;
    end
  end

  mdr_state_e       state_q;
  logic             ack_q;
  lv_e  [WIDTH-1:0] cap_res_q;
  logic             cap_conf_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xz_q, xz_d;
  logic             loop_fb_q;

  // Statistics next-state; a clear discards a coincident capture event.
  always_comb begin
    cnt_d = cnt_q;
    xz_d  = xz_q;
    if (bus.stat_clr) begin
      cnt_d = '0;
      xz_d  = 1'b0;
    end else if (state_q == ST_CAPTURE) begin
      if (conflict_w && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      if (any_xz_w) xz_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      cap_conf_q <= 1'b0;
      cnt_q      <= '0;
      xz_q       <= 1'b0;
      for (int unsigned b = 0; b < WIDTH; b++) begin
        cap_res_q[b] <= LV_0;
      end
    end else begin
      cnt_q <= cnt_d;
      xz_q  <= xz_d;
      ack_q <= (state_q == ST_HOLD);
      case (state_q)
        ST_IDLE: begin
          if (bus.sample_req) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          cap_res_q  <= res_w;
          cap_conf_q <= conflict_w;
          state_q    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!bus.sample_req) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          loop_fb_q <= 1'b0;
    else if (loop_en) loop_fb_q <= ~loop_fb_q;
  end

  assign bus.sample_ack   = ack_q;
  assign bus.res_q        = cap_res_q;
  assign bus.conflict_q   = cap_conf_q;
  assign bus.xz_seen      = xz_q;
  assign bus.conflict_cnt = cnt_q;
  assign loop_q           = loop_fb_q;

endmodule

// File: tb/tb_multi_drive_resolver.sv
// -----------------------------------------------------------------------------
// tb_multi_drive_resolver
// Four resolvers share one stimulus: tri, wor, wand (16-bit counters) and a
// tri instance with a 2-bit counter for saturation. Expected values come from
// a list-based reference model of the net rules.
// -----------------------------------------------------------------------------
module tb_multi_drive_resolver;
  import mdr_pkg::*;

  localparam int ND = 4;
  localparam int W  = 8;

  logic clk, rst, loop_en;
  logic [3:0] loop_q;
  logic [ND-1:0]        drv_en;
  lv_e  [ND-1:0][W-1:0] drv_val;
  logic sample_req, stat_clr;

  int checks   = 0;
  int failures = 0;

  int          mode_of [4] = '{0, 1, 2, 0};
  int unsigned cmax    [4] = '{65535, 65535, 65535, 3};
  int unsigned exp_cnt [4];
  bit          exp_xz  [4];

  multi_drive_resolver_if #(.NUM_DRV(ND), .WIDTH(W), .CNT_W(16)) if_tri ();
  multi_drive_resolver_if #(.NUM_DRV(ND), .WIDTH(W), .CNT_W(16)) if_wor ();
  multi_drive_resolver_if #(.NUM_DRV(ND), .WIDTH(W), .CNT_W(16)) if_wand ();
  multi_drive_resolver_if #(.NUM_DRV(ND), .WIDTH(W), .CNT_W(2))  if_sat ();

  assign if_tri.drv_en  = drv_en;  assign if_tri.drv_val  = drv_val;
  assign if_tri.sample_req  = sample_req; assign if_tri.stat_clr  = stat_clr;
  assign if_wor.drv_en  = drv_en;  assign if_wor.drv_val  = drv_val;
  assign if_wor.sample_req  = sample_req; assign if_wor.stat_clr  = stat_clr;
  assign if_wand.drv_en = drv_en;  assign if_wand.drv_val = drv_val;
  assign if_wand.sample_req = sample_req; assign if_wand.stat_clr = stat_clr;
  assign if_sat.drv_en  = drv_en;  assign if_sat.drv_val  = drv_val;
  assign if_sat.sample_req  = sample_req; assign if_sat.stat_clr  = stat_clr;

  multi_drive_resolver #(.NUM_DRV(ND), .WIDTH(W), .MODE(0), .CNT_W(16)) u_tri (
    .clk(clk), .rst(rst), .bus(if_tri), .loop_en(loop_en), .loop_q(loop_q[0]));
  multi_drive_resolver #(.NUM_DRV(ND), .WIDTH(W), .MODE(1), .CNT_W(16)) u_wor (
    .clk(clk), .rst(rst), .bus(if_wor), .loop_en(loop_en), .loop_q(loop_q[1]));
  multi_drive_resolver #(.NUM_DRV(ND), .WIDTH(W), .MODE(2), .CNT_W(16)) u_wand (
    .clk(clk), .rst(rst), .bus(if_wand), .loop_en(loop_en), .loop_q(loop_q[2]));
  multi_drive_resolver #(.NUM_DRV(ND), .WIDTH(W), .MODE(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .bus(if_sat), .loop_en(loop_en), .loop_q(loop_q[3]));

  lv_e  [W-1:0] o_res  [4];
  logic         o_ack  [4];
  logic         o_conf [4];
  logic         o_xz   [4];
  logic [15:0]  o_cnt  [4];

  assign o_res[0] = if_tri.res_q;  assign o_res[1] = if_wor.res_q;
  assign o_res[2] = if_wand.res_q; assign o_res[3] = if_sat.res_q;
  assign o_ack[0] = if_tri.sample_ack;  assign o_ack[1] = if_wor.sample_ack;
  assign o_ack[2] = if_wand.sample_ack; assign o_ack[3] = if_sat.sample_ack;
  assign o_conf[0] = if_tri.conflict_q;  assign o_conf[1] = if_wor.conflict_q;
  assign o_conf[2] = if_wand.conflict_q; assign o_conf[3] = if_sat.conflict_q;
  assign o_xz[0] = if_tri.xz_seen;  assign o_xz[1] = if_wor.xz_seen;
  assign o_xz[2] = if_wand.xz_seen; assign o_xz[3] = if_sat.xz_seen;
  assign o_cnt[0] = if_tri.conflict_cnt;  assign o_cnt[1] = if_wor.conflict_cnt;
  assign o_cnt[2] = if_wand.conflict_cnt; assign o_cnt[3] = {14'b0, if_sat.conflict_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic lv_e [W-1:0] to_lv(input logic [W-1:0] v);
    lv_e [W-1:0] r;
    for (int b = 0; b < W; b++) r[b] = v[b] ? LV_1 : LV_0;
    return r;
  endfunction

  function automatic lv_e [W-1:0] all_lv(input lv_e v);
    lv_e [W-1:0] r;
    for (int b = 0; b < W; b++) r[b] = v;
    return r;
  endfunction

  function automatic bit has(input lv_e q[$], input lv_e v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: gather the non-z contributions of each bit, then apply the
  // net rule to that list.
  function automatic lv_e [W-1:0] ref_net(input int mode, input logic [ND-1:0] en,
                                          input lv_e [ND-1:0][W-1:0] v, output bit conf);
    lv_e [W-1:0] r;
    conf = 1'b0;
    for (int b = 0; b < W; b++) begin
      lv_e q[$];
      for (int d = 0; d < ND; d++)
        if (en[d] && v[d][b] != LV_Z) q.push_back(v[d][b]);
      if (has(q, LV_0) && has(q, LV_1)) conf = 1'b1;
      if (q.size() == 0) r[b] = LV_Z;
      else if (mode == 1) r[b] = has(q, LV_1) ? LV_1 : has(q, LV_X) ? LV_X : LV_0;
      else if (mode == 2) r[b] = has(q, LV_0) ? LV_0 : has(q, LV_X) ? LV_X : LV_1;
      else begin
        r[b] = q[0];
        foreach (q[i]) if (q[i] != q[0]) r[b] = LV_X;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin exp_cnt[i] = 0; exp_xz[i] = 1'b0; end
  endtask

  // Enters at a negedge with drivers set; leaves in HOLD with req high.
  task automatic capture(input bit clr);
    lv_e [W-1:0] er [4];
    bit ec [4];
    sample_req = 1'b1;
    @(posedge clk); @(negedge clk);
    stat_clr = clr;
    check("ack_not_early", 32'(o_ack[0]), 0);
    for (int i = 0; i < 4; i++) er[i] = ref_net(mode_of[i], drv_en, drv_val, ec[i]);
    @(posedge clk); @(negedge clk);
    stat_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit ax;
      ax = 1'b0;
      for (int b = 0; b < W; b++) if (er[i][b] == LV_X || er[i][b] == LV_Z) ax = 1'b1;
      if (clr) begin
        exp_cnt[i] = 0; exp_xz[i] = 1'b0;
      end else begin
        if (ec[i] && exp_cnt[i] < cmax[i]) exp_cnt[i]++;
        if (ax) exp_xz[i] = 1'b1;
      end
    end
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ack%0d", i),  32'(o_ack[i]),  1);
      check($sformatf("res%0d", i),  32'(o_res[i]),  32'(er[i]));
      check($sformatf("conf%0d", i), 32'(o_conf[i]), 32'(ec[i]));
      check($sformatf("cnt%0d", i),  32'(o_cnt[i]),  exp_cnt[i]);
      check($sformatf("xz%0d", i),   32'(o_xz[i]),   32'(exp_xz[i]));
    end
  endtask

  task automatic release_req();
    sample_req = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("ack_drop%0d", i), 32'(o_ack[i]), 0);
  endtask

  task automatic set_drv(input logic [ND-1:0] en, input lv_e [W-1:0] d0,
                         input lv_e [W-1:0] d1, input lv_e [W-1:0] d2);
    drv_en = en;
    drv_val[0] = d0; drv_val[1] = d1; drv_val[2] = d2; drv_val[3] = all_lv(LV_Z);
  endtask

  initial begin
    rst = 1'b1; loop_en = 1'b0; sample_req = 1'b0; stat_clr = 1'b0;
    drv_en = '0;
    for (int d = 0; d < ND; d++) drv_val[d] = all_lv(LV_Z);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_ack%0d", i),  32'(o_ack[i]),  0);
      check($sformatf("rst_res%0d", i),  32'(o_res[i]),  32'(to_lv(8'h00)));
      check($sformatf("rst_cnt%0d", i),  32'(o_cnt[i]),  0);
      check($sformatf("rst_loop%0d", i), 32'(loop_q[i]), 0);
    end

    // Registered toggle: 1,0,1,0,1 then hold.
    rst = 1'b0; loop_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("loop_step%0d", i), 32'(loop_q[0]), (i % 2 == 0) ? 1 : 0);
    end
    loop_en = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("loop_hold", 32'(loop_q[0]), 1);
    end

    // Agreeing drivers.
    set_drv(4'b0011, to_lv(8'hA5), to_lv(8'hA5), all_lv(LV_Z));
    capture(1'b0);
    check("a5_res", 32'(o_res[0]), 32'(to_lv(8'hA5)));
    check("a5_conf", 32'(o_conf[0]), 0);
    release_req();

    // Opposing drivers, four captures.
    set_drv(4'b0011, to_lv(8'hF0), to_lv(8'h0F), all_lv(LV_Z));
    repeat (4) begin capture(1'b0); release_req(); end
    check("f0_res_allx", 32'(o_res[0]), 32'(all_lv(LV_X)));
    check("f0_cnt4", 32'(o_cnt[0]), 4);
    check("sat_cnt3", 32'(o_cnt[3]), 3);

    // Wired nets with a z driver.
    set_drv(4'b0111, to_lv(8'h01), to_lv(8'h10), all_lv(LV_Z));
    capture(1'b0);
    check("wor_res", 32'(o_res[1]), 32'(to_lv(8'h11)));
    check("wand_res", 32'(o_res[2]), 32'(to_lv(8'h00)));
    check("wor_xz0", 32'(o_xz[1]), 0);
    check("sat_hold3", 32'(o_cnt[3]), 3);
    release_req();

    // Clear coinciding with a conflicting capture.
    capture(1'b1);
    check("clr_sat_cnt", 32'(o_cnt[3]), 0);
    check("clr_tri_xz", 32'(o_xz[0]), 0);
    release_req();

    // All drivers disabled, then reset during HOLD with req held.
    set_drv(4'b0000, to_lv(8'h12), to_lv(8'h34), to_lv(8'h56));
    capture(1'b0);
    check("alloff_res_z", 32'(o_res[2]), 32'(all_lv(LV_Z)));
    check("alloff_xz", 32'(o_xz[1]), 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hrst_ack%0d", i), 32'(o_ack[i]), 0);
      check($sformatf("hrst_res%0d", i), 32'(o_res[i]), 32'(to_lv(8'h00)));
      check($sformatf("hrst_xz%0d", i),  32'(o_xz[i]),  0);
    end
    capture(1'b0);
    release_req();

    // Randomized captures with occasional clears.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] base;
      base = W'($urandom);
      drv_en = ND'($urandom);
      for (int d = 0; d < ND; d++)
        for (int b = 0; b < W; b++)
          drv_val[d][b] = ($urandom_range(0, 3) != 0) ? (base[b] ? LV_1 : LV_0)
                                                      : lv_e'($urandom_range(0, 3));
      capture($urandom_range(0, 7) == 0);
      release_req();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
